// File: rtl/uart_pkg.sv
// Shared UART framing definitions: state encoding, data width, default rates
// and the parity helper used by both transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS         = 8;
  localparam int DEFAULT_BAUD_RATE = 9600;
  localparam int DEFAULT_CLK_FREQ  = 100_000_000;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit,
// and restarts from zero whenever a new frame is loaded.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start, 8 data LSB-first, even parity, 1 stop, with a
// one-byte holding buffer so consecutive frames run back to back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE    = DEFAULT_BAUD_RATE,
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_t          state;
  logic [DATA_BITS-1:0] hold;
  logic                 full;
  logic [DATA_BITS-1:0] shift;
  logic                 parity;
  logic [2:0]           bit_idx;
  logic                 bit_tick;
  logic                 load;
  logic                 accept;

  // A frame loads from IDLE, or straight out of the final stop-bit cycle.
  always_comb begin
    load = 1'b0;
    if (full) begin
      if (state == IDLE) load = 1'b1;
      else if (state == STOP && bit_tick) load = 1'b1;
    end
  end

  assign accept   = tx_valid && !full;
  assign tx_ready = !full;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == STOP) && bit_tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (load),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      full <= 1'b0;
    end else begin
      if (accept) hold <= tx_data;
      full <= (full && !load) || accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      parity  <= 1'b0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else if (load) begin
      state   <= START;
      shift   <= hold;
      parity  <= even_parity(hold);
      bit_idx <= '0;
      tx      <= 1'b0;
    end else if (bit_tick) begin
      case (state)
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shift[0];
        end
        DATA: begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state <= PARITY;
            tx    <= parity;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shift   <= shift >> 1;
            tx      <= shift[1];
          end
        end
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed + random bench for uart_transmitter with CLKS_PER_BIT=16; expected
// line waveforms are built from the frame format with plain arithmetic.
module tb_uart_transmitter;

  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for each of the 176 cycles of one frame carrying b.
  function automatic logic [FRAME-1:0] frame_wave(input logic [7:0] b);
    logic [10:0]      bits;
    logic [FRAME-1:0] w;
    bits = {1'b1, 1'($countones(b) % 2), b, 1'b0};
    for (int c = 0; c < FRAME; c++) w[c] = bits[c / CPB];
    return w;
  endfunction

  task automatic send_frame(input string tag, input logic [7:0] b);
    logic [FRAME-1:0] tx_log, busy_log, done_log, exp_done;
    logic [7:0]       rx_byte;
    logic             rx_par;
    logic             rdy;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    rdy      = tx_ready;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk({tag, "_ready"}, 528'(rdy), 528'(1));
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk);
      #1;
      tx_log[c]   = tx;
      busy_log[c] = tx_busy;
      done_log[c] = tx_done;
    end
    exp_done = '0;
    exp_done[FRAME-1] = 1'b1;
    chk({tag, "_tx"}, 528'(tx_log), 528'(frame_wave(b)));
    chk({tag, "_busy"}, 528'(busy_log), 528'({FRAME{1'b1}}));
    chk({tag, "_done"}, 528'(done_log), 528'(exp_done));
    for (int i = 0; i < 8; i++) rx_byte[i] = tx_log[CPB * (i + 1) + CPB / 2];
    rx_par = tx_log[CPB * 9 + CPB / 2];
    chk({tag, "_rx_data"}, 528'(rx_byte), 528'(b));
    chk({tag, "_rx_parity_err"}, 528'(^{rx_byte, rx_par}), 528'(0));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, 528'({tx, tx_busy, tx_ready}), 528'(3'b101));
  endtask

  initial begin
    logic [7:0]       bytes [3];
    int               acc   [3];
    int               k;
    int               dones;
    logic             rdy;
    logic [3*FRAME-1:0] line_log;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 528'({tx, tx_ready, tx_busy, tx_done}), 528'(4'b1100));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send_frame("b55", 8'h55);
    send_frame("b07", 8'h07);
    send_frame("b00", 8'h00);
    send_frame("bFF", 8'hFF);
    send_frame("b5A", 8'h5A);
    send_frame("bC3", 8'hC3);
    for (int r = 0; r < 4; r++) send_frame("rand", 8'($urandom));

    // Three bytes offered with tx_valid held high: frames must be contiguous.
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h81;
    k = 0;
    dones = 0;
    line_log = '0;
    for (int cyc = 0; cyc <= 3 * FRAME + 4; cyc++) begin
      @(negedge clk);
      if (k < 3) begin
        tx_valid = 1'b1;
        tx_data  = bytes[k];
      end else begin
        tx_valid = 1'b0;
      end
      rdy = tx_ready;
      @(posedge clk);
      if (tx_valid && rdy) begin
        acc[k] = cyc;
        k++;
      end
      #1;
      if (cyc >= 1 && cyc <= 3 * FRAME) line_log[cyc-1] = tx;
      if (tx_done) dones++;
    end
    tx_valid = 1'b0;
    chk("b2b_accepted", 528'(k), 528'(3));
    chk("b2b_accept0", 528'(acc[0]), 528'(0));
    chk("b2b_accept1", 528'(acc[1]), 528'(2));
    chk("b2b_accept2", 528'(acc[2]), 528'(FRAME + 2));
    chk("b2b_line", 528'(line_log),
        528'({frame_wave(bytes[2]), frame_wave(bytes[1]), frame_wave(bytes[0])}));
    chk("b2b_done_count", 528'(dones), 528'(3));
    chk("b2b_idle", 528'({tx, tx_busy, tx_ready}), 528'(3'b101));

    // A valid pulse while the buffer is full must be ignored.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h22;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    rdy      = tx_ready;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("ignored_ready", 528'(rdy), 528'(0));
    dones = 0;
    for (int c = 0; c < 2 * FRAME + 60; c++) begin
      @(posedge clk);
      #1;
      if (tx_done) dones++;
    end
    chk("ignored_frames", 528'(dones), 528'(2));
    chk("ignored_idle", 528'({tx, tx_busy, tx_ready}), 528'(3'b101));

    // Reset in the middle of a frame.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    chk("pre_reset_busy", 528'(tx_busy), 528'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 528'({tx, tx_busy, tx_ready, tx_done}), 528'(4'b1010));
    @(negedge clk);
    rst_n = 1'b1;
    send_frame("after_reset", 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
